// File: rtl/float_discriminant_sched.sv
// Sequencer for the FP64 discriminant b*b - 4*a*c.
// A single shared multiplier and a single shared subtractor are time-multiplexed
// by one FSM. Handshake to each unit: *_up_valid is a one-cycle issue pulse that
// is raised only while the unit's busy input is low; the unit answers later with
// a one-cycle *_down_valid carrying *_res and *_error. The result leaves as a
// one-cycle res_vld pulse; arg_vld is accepted only while busy is low.
module float_discriminant_sched #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err,
  output logic            busy,
  output logic [FLEN-1:0] mul_a,
  output logic [FLEN-1:0] mul_b,
  output logic            mul_up_valid,
  input  logic [FLEN-1:0] mul_res,
  input  logic            mul_down_valid,
  input  logic            mul_busy,
  input  logic            mul_error,
  output logic [FLEN-1:0] sub_a,
  output logic [FLEN-1:0] sub_b,
  output logic            sub_up_valid,
  input  logic [FLEN-1:0] sub_res,
  input  logic            sub_down_valid,
  input  logic            sub_busy,
  input  logic            sub_error,
  output logic [3:0]      dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ISS_BB  = 4'd1,
    S_W_BB    = 4'd2,
    S_ISS_AC  = 4'd3,
    S_W_AC    = 4'd4,
    S_ISS_4AC = 4'd5,
    S_W_4AC   = 4'd6,
    S_ISS_SUB = 4'd7,
    S_W_SUB   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [FLEN-1:0] FP_FOUR = 64'h4010_0000_0000_0000;
  localparam logic [FLEN-1:0] FP_QNAN = 64'h7FF8_0000_0000_0000;

  state_t          r_state;
  logic [FLEN-1:0] r_a;
  logic [FLEN-1:0] r_c;
  logic [FLEN-1:0] r_bb;
  logic            r_err_acc;
  logic            r_res_vld;
  logic [FLEN-1:0] r_res;
  logic            r_res_negative;
  logic            r_err;
  logic            r_busy;
  logic [FLEN-1:0] r_mul_a;
  logic [FLEN-1:0] r_mul_b;
  logic [FLEN-1:0] r_sub_a;
  logic [FLEN-1:0] r_sub_b;

  logic w_accept;
  logic w_bad_operand;

  // New operands are taken in IDLE and also in DONE, where busy is already low.
  assign w_accept      = arg_vld && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Inf or NaN on any operand: exponent field all ones.
  assign w_bad_operand = (&a[62:52]) || (&b[62:52]) || (&c[62:52]);

  // Issue pulses come straight from the state so they are granted in the same
  // cycle the unit reports not-busy; state is reset asynchronously, so they drop
  // to zero with reset.
  assign mul_up_valid = ((r_state == S_ISS_BB) || (r_state == S_ISS_AC) ||
                         (r_state == S_ISS_4AC)) && !mul_busy;
  assign sub_up_valid = (r_state == S_ISS_SUB) && !sub_busy;

  assign res_vld      = r_res_vld;
  assign res          = r_res;
  assign res_negative = r_res_negative;
  assign err          = r_err;
  assign busy         = r_busy;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign sub_a        = r_sub_a;
  assign sub_b        = r_sub_b;
  assign dbg_state    = r_state;

  // Sequencing FSM. The operand bus registers are loaded one step ahead so they
  // are stable in the ISS_x cycle; mul_* holds a*c while it is scaled by 4.0 and
  // sub_b holds 4ac until the subtraction, so they double as step registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_c            <= '0;
      r_bb           <= '0;
      r_err_acc      <= 1'b0;
      r_res_vld      <= 1'b0;
      r_res          <= '0;
      r_res_negative <= 1'b0;
      r_err          <= 1'b0;
      r_busy         <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_sub_a        <= '0;
      r_sub_b        <= '0;
    end else begin
      r_res_vld <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            r_a       <= a;
            r_c       <= c;
            r_err_acc <= 1'b0;
            if (w_bad_operand) begin
              r_state        <= S_DONE;
              r_res          <= FP_QNAN;
              r_res_negative <= 1'b0;
              r_err          <= 1'b1;
              r_res_vld      <= 1'b1;
            end else begin
              r_state <= S_ISS_BB;
              r_busy  <= 1'b1;
              r_mul_a <= b;
              r_mul_b <= b;
            end
          end
        end
        S_ISS_BB:  if (!mul_busy) r_state <= S_W_BB;
        S_W_BB: begin
          if (mul_down_valid) begin
            r_bb      <= mul_res;
            r_err_acc <= r_err_acc | mul_error;
            r_mul_a   <= r_a;
            r_mul_b   <= r_c;
            r_state   <= S_ISS_AC;
          end
        end
        S_ISS_AC:  if (!mul_busy) r_state <= S_W_AC;
        S_W_AC: begin
          if (mul_down_valid) begin
            r_err_acc <= r_err_acc | mul_error;
            r_mul_a   <= mul_res;
            r_mul_b   <= FP_FOUR;
            r_state   <= S_ISS_4AC;
          end
        end
        S_ISS_4AC: if (!mul_busy) r_state <= S_W_4AC;
        S_W_4AC: begin
          if (mul_down_valid) begin
            r_err_acc <= r_err_acc | mul_error;
            r_sub_a   <= r_bb;
            r_sub_b   <= mul_res;
            r_state   <= S_ISS_SUB;
          end
        end
        S_ISS_SUB: if (!sub_busy) r_state <= S_W_SUB;
        S_W_SUB: begin
          if (sub_down_valid) begin
            r_res          <= sub_res;
            r_res_negative <= sub_res[FLEN-1];
            r_err          <= r_err_acc | sub_error;
            r_res_vld      <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_DONE;
          end
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_discriminant_sched.sv
// Testbench for float_discriminant_sched: fixed-latency unit stubs doing real
// FP64 arithmetic, a driver that issues operations, and a monitor that pops
// expected results from a queue whenever res_vld is seen.
module tb_float_discriminant_sched;

  localparam int          L       = 3;
  localparam logic [63:0] FP_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] FP_TWO  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] FP_THR  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] FP_FOUR = 64'h4010_0000_0000_0000;
  localparam logic [63:0] FP_INF  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] FP_QNAN = 64'h7FF8_0000_0000_0000;

  typedef struct {
    logic [63:0] res;
    logic        neg;
    logic        err;
    int          cyc;
    int          n_mul;
    int          n_sub;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        arg_vld = 1'b0;
  logic [63:0] a = '0, b = '0, c = '0;
  logic        res_vld, res_negative, err, busy;
  logic [63:0] res;
  logic [63:0] mul_a, mul_b, mul_res, sub_a, sub_b, sub_res;
  logic        mul_up_valid, mul_down_valid, mul_error;
  logic        sub_up_valid, sub_down_valid, sub_error;
  logic        mul_busy = 1'b0;
  logic        sub_busy = 1'b0;
  logic [3:0]  dbg_state;

  logic inj_mul4 = 1'b0;   // error flag on the 4*ac multiply
  logic inj_sub  = 1'b0;   // error flag on the subtraction
  logic stray    = 1'b0;   // spurious down_valid on both units

  float_discriminant_sched #(.FLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res(res), .res_negative(res_negative), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_up_valid(mul_up_valid), .mul_res(mul_res),
    .mul_down_valid(mul_down_valid), .mul_busy(mul_busy), .mul_error(mul_error),
    .sub_a(sub_a), .sub_b(sub_b), .sub_up_valid(sub_up_valid), .sub_res(sub_res),
    .sub_down_valid(sub_down_valid), .sub_busy(sub_busy), .sub_error(sub_error),
    .dbg_state(dbg_state)
  );

  // ---------------- unit stubs: latency L, real arithmetic ----------------
  logic        m_v[L];
  logic [63:0] m_d[L];
  logic        m_e[L];
  logic        s_v[L];
  logic [63:0] s_d[L];
  logic        s_e[L];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        m_v[i] <= 1'b0; m_d[i] <= '0; m_e[i] <= 1'b0;
        s_v[i] <= 1'b0; s_d[i] <= '0; s_e[i] <= 1'b0;
      end
    end else begin
      m_v[0] <= mul_up_valid;
      m_d[0] <= $realtobits($bitstoreal(mul_a) * $bitstoreal(mul_b));
      m_e[0] <= mul_up_valid && inj_mul4 && (mul_b == FP_FOUR);
      s_v[0] <= sub_up_valid;
      s_d[0] <= $realtobits($bitstoreal(sub_a) - $bitstoreal(sub_b));
      s_e[0] <= sub_up_valid && inj_sub;
      for (int i = 1; i < L; i++) begin
        m_v[i] <= m_v[i-1]; m_d[i] <= m_d[i-1]; m_e[i] <= m_e[i-1];
        s_v[i] <= s_v[i-1]; s_d[i] <= s_d[i-1]; s_e[i] <= s_e[i-1];
      end
    end
  end

  assign mul_down_valid = m_v[L-1] | stray;
  assign mul_res        = stray ? 64'hDEAD_BEEF_0BAD_F00D : m_d[L-1];
  assign mul_error      = m_e[L-1] | stray;
  assign sub_down_valid = s_v[L-1] | stray;
  assign sub_res        = stray ? 64'hC0FF_EE00_1234_5678 : s_d[L-1];
  assign sub_error      = s_e[L-1] | stray;

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fails = 0;
  int   n_mul   = 0;
  int   n_sub   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: discriminant from the plain formula in IEEE double arithmetic.
  function automatic exp_t model(input logic [63:0] fa, input logic [63:0] fb,
                                 input logic [63:0] fc, input int bp,
                                 input logic em, input logic es, input int acc);
    exp_t e;
    real  ra, rb, rc, d;
    if ((&fa[62:52]) || (&fb[62:52]) || (&fc[62:52])) begin
      e.res = FP_QNAN; e.neg = 1'b0; e.err = 1'b1;
      e.cyc = acc; e.n_mul = 0; e.n_sub = 0;
    end else begin
      ra = $bitstoreal(fa); rb = $bitstoreal(fb); rc = $bitstoreal(fc);
      d  = (rb * rb) - ((ra * rc) * 4.0);
      e.res = $realtobits(d); e.neg = e.res[63]; e.err = em | es;
      e.cyc = acc + 4 * L + 4 + bp; e.n_mul = 3; e.n_sub = 1;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_busy) chk("mul_issue_while_busy", {63'd0, mul_up_valid}, 64'd0);
      if (mul_up_valid) n_mul++;
      if (sub_up_valid) n_sub++;
      if (res_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_vld", {63'd0, res_vld}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res",          res, e.res);
          chk("res_negative", {63'd0, res_negative}, {63'd0, e.neg});
          chk("err",          {63'd0, err}, {63'd0, e.err});
          chk("res_cycle",    64'(cyc), 64'(e.cyc));
          chk("mul_pulses",   64'(n_mul), 64'(e.n_mul));
          chk("sub_pulses",   64'(n_sub), 64'(e.n_sub));
          chk("busy_in_done", {63'd0, busy}, 64'd0);
        end
        n_mul = 0;
        n_sub = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered #1 after a posedge; leaves #1 after the accepting posedge.
  task automatic issue(input logic [63:0] fa, input logic [63:0] fb, input logic [63:0] fc,
                       input int bp, input logic em, input logic es);
    int acc;
    chk("ready_for_arg", {63'd0, busy}, 64'd0);
    arg_vld = 1'b1; a = fa; b = fb; c = fc;
    inj_mul4 = em; inj_sub = es;
    @(posedge clk); #1;
    acc = cyc;
    arg_vld = 1'b0;
    mul_busy = (bp > 0);
    exp_q.push_back(model(fa, fb, fc, bp, em, es, acc));
  endtask

  // Runs until res_vld is visible; returns #1 after the posedge that raised it.
  task automatic wait_done(input int bp, input bit poke);
    int k = 0;
    while (!res_vld && k < 400) begin
      if (k == bp) mul_busy = 1'b0;
      if (poke && k == 5) begin
        arg_vld = 1'b1; a = FP_TWO; b = FP_INF; c = FP_THR;
      end
      if (poke && k == 6) arg_vld = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    arg_vld  = 1'b0;
    mul_busy = 1'b0;
    chk("done_within_bound", {63'd0, res_vld}, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] fa, input logic [63:0] fb, input logic [63:0] fc,
                        input int bp, input logic em, input logic es, input bit poke, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    issue(fa, fb, fc, bp, em, es);
    wait_done(bp, poke);
  endtask

  function automatic logic [63:0] rnd_fp();
    logic [10:0] ex;
    ex = 11'(1003 + $urandom_range(0, 40));
    return {1'($urandom_range(0, 1)), ex, 32'($urandom), 20'($urandom)};
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_res_vld"}, {63'd0, res_vld}, 64'd0);
    chk({tag, "_res"},     res, 64'd0);
    chk({tag, "_res_neg"}, {63'd0, res_negative}, 64'd0);
    chk({tag, "_err"},     {63'd0, err}, 64'd0);
    chk({tag, "_busy"},    {63'd0, busy}, 64'd0);
    chk({tag, "_mul_up"},  {63'd0, mul_up_valid}, 64'd0);
    chk({tag, "_sub_up"},  {63'd0, sub_up_valid}, 64'd0);
    chk({tag, "_mul_a"},   mul_a, 64'd0);
    chk({tag, "_sub_b"},   sub_b, 64'd0);
    chk({tag, "_state"},   {60'd0, dbg_state}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] ra, rb, rc;
    int          bp, gap;
    logic        em, es;

    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(FP_ONE, FP_THR, FP_TWO, 0, 1'b0, 1'b0, 1'b0, 1);   // 9-8 = 1
    run_op(FP_ONE, FP_ONE, FP_ONE, 0, 1'b0, 1'b0, 1'b0, 2);   // 1-4 = -3
    run_op(FP_INF, FP_ONE, FP_ONE, 0, 1'b0, 1'b0, 1'b0, 2);   // invalid operand
    run_op(FP_ONE, FP_THR, FP_TWO, 5, 1'b0, 1'b0, 1'b0, 2);   // multiplier back-pressure
    run_op(FP_TWO, FP_THR, FP_ONE, 0, 1'b1, 1'b0, 1'b0, 2);   // error on 4ac step
    run_op(FP_TWO, FP_ONE, FP_THR, 0, 1'b0, 1'b0, 1'b1, 2);   // arg_vld poked mid-op
    run_op(FP_THR, FP_ONE, FP_TWO, 0, 1'b0, 1'b0, 1'b0, 0);   // accepted in DONE
    run_op(FP_ONE, FP_QNAN, FP_ONE, 0, 1'b0, 1'b0, 1'b0, 0);  // back-to-back, invalid
    run_op(FP_ONE, FP_TWO, FP_ONE, 0, 1'b0, 1'b1, 1'b0, 0);   // back-to-back, sub error

    // Asynchronous reset in cycle 8 of an operation.
    @(posedge clk); #1;
    issue(FP_ONE, FP_THR, FP_TWO, 0, 1'b0, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("midop_reset");
    exp_q.delete();
    n_mul = 0;
    n_sub = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    @(posedge clk); #1;
    chk("stray_busy",  {63'd0, busy}, 64'd0);
    chk("stray_state", {60'd0, dbg_state}, 64'd0);
    run_op(FP_ONE, FP_ONE, FP_ONE, 0, 1'b0, 1'b0, 1'b0, 1);

    // Randomised operations.
    for (int n = 0; n < 30; n++) begin
      ra = rnd_fp(); rb = rnd_fp(); rc = rnd_fp();
      case ($urandom_range(0, 9))
        0: ra[62:52] = 11'h7FF;
        1: rc = {rc[63], 11'h7FF, 52'h8_0000_0000_0001};
        default: ;
      endcase
      bp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      gap = int'($urandom_range(0, 3));
      em  = ($urandom_range(0, 7) == 0);
      es  = ($urandom_range(0, 7) == 0);
      run_op(ra, rb, rc, bp, em, es, 1'b0, gap);
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
